// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the interrupt pending controller.
package irq_pkg;

    localparam int N_REQ = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESENT = 2'd1,
        ST_GAP     = 2'd2
    } irq_state_t;

endpackage

// File: rtl/prio_enc_8to3.sv
// Combinational priority encoder: index of the highest set bit (bit 7 wins).
module prio_enc_8to3
    import irq_pkg::*;
(
    input  logic [N_REQ-1:0] i_vec,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_any
);

    // Ascending scan so the last (highest) set bit overwrites lower ones.
    always_comb begin
        o_idx = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (i_vec[i]) begin
                o_idx = IDX_W'(i);
            end
        end
    end

    assign o_any = |i_vec;

endmodule

// File: rtl/irq_pending_ctrl.sv
// Interrupt front-end: edge capture, pending register, masked priority
// selection and valid/ack presentation with a mandatory gap between grants.
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req_in,
    input  logic [N_REQ-1:0] mask,
    input  logic             irq_ack,
    output logic             irq_valid,
    output logic [IDX_W-1:0] irq_idx,
    output logic [N_REQ-1:0] pending
);

    logic [N_REQ-1:0] r_req_prev;
    logic [N_REQ-1:0] r_pending;
    irq_state_t       r_state;
    logic             r_valid;
    logic [IDX_W-1:0] r_idx;

    logic [N_REQ-1:0] w_new_req;
    logic [N_REQ-1:0] w_clr;
    logic [N_REQ-1:0] w_eligible;
    logic [IDX_W-1:0] w_sel;
    logic             w_any;
    logic             w_ack;

    assign w_new_req  = req_in & ~r_req_prev;
    assign w_ack      = (r_state == ST_PRESENT) && irq_ack;
    assign w_clr      = w_ack ? (N_REQ'(1) << r_idx) : '0;
    assign w_eligible = r_pending & mask;

    prio_enc_8to3 u_prio (
        .i_vec (w_eligible),
        .o_idx (w_sel),
        .o_any (w_any)
    );

    // Set after clear so a new edge on the serviced bit keeps it pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_req_prev <= '0;
            r_pending  <= '0;
        end else begin
            r_req_prev <= req_in;
            r_pending  <= (r_pending & ~w_clr) | w_new_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_valid <= 1'b0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_idx   <= w_sel;
                        r_valid <= 1'b1;
                        r_state <= ST_PRESENT;
                    end
                end
                ST_PRESENT: begin
                    if (irq_ack) begin
                        r_valid <= 1'b0;
                        r_state <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_valid <= 1'b0;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign irq_valid = r_valid;
    assign irq_idx   = r_idx;
    assign pending   = r_pending;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed and randomized checks of irq_pending_ctrl against a behavioural model.
module tb_irq_pending_ctrl;

    logic       clk;
    logic       rst_n;
    logic [7:0] req_in;
    logic [7:0] mask;
    logic       irq_ack;
    logic       irq_valid;
    logic [2:0] irq_idx;
    logic [7:0] pending;

    int checks;
    int failures;

    logic [7:0] m_pend;
    logic [7:0] m_prev;
    logic       m_valid;
    logic [2:0] m_idx;
    logic       m_gap;

    irq_pending_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_in    (req_in),
        .mask      (mask),
        .irq_ack   (irq_ack),
        .irq_valid (irq_valid),
        .irq_idx   (irq_idx),
        .pending   (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2:0] highest(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) begin
            if (v[i]) return 3'(i);
        end
        return 3'd0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_prev  = '0;
        m_valid = 1'b0;
        m_idx   = '0;
        m_gap   = 1'b0;
    endtask

    // One clock: advance the model from the values seen at the edge, then compare.
    task automatic step();
        logic [7:0] nreq;
        logic [7:0] clr;
        @(posedge clk);
        nreq = req_in & ~m_prev;
        clr  = (m_valid && irq_ack) ? (8'd1 << m_idx) : 8'd0;
        if (m_valid) begin
            if (irq_ack) begin
                m_valid = 1'b0;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if ((m_pend & mask) != 0) begin
            m_valid = 1'b1;
            m_idx   = highest(m_pend & mask);
        end
        m_pend = (m_pend & ~clr) | nreq;
        m_prev = req_in;
        #1;
        chk("model_valid", 8'(irq_valid), 8'(m_valid));
        chk("model_idx", 8'(irq_idx), 8'(m_idx));
        chk("model_pending", pending, m_pend);
    endtask

    task automatic wait_grant(input logic [2:0] exp, input int budget);
        int n;
        n = 0;
        while (!irq_valid && n < budget) begin
            step();
            n++;
        end
        chk("grant_seen", 8'(irq_valid), 8'd1);
        chk("grant_idx", 8'(irq_idx), 8'(exp));
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
    endtask

    logic [8:0] held_v;
    logic [2:0] held_i [3];
    int         gi;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req_in   = '0;
        mask     = 8'hFF;
        irq_ack  = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_valid", 8'(irq_valid), 8'd0);
            chk("idle_pending", pending, 8'h00);
        end
        chk("idle_idx", 8'(irq_idx), 8'd0);

        // Single held request on bit 3
        req_in = 8'h08;
        step();
        chk("single_pend_e0", pending, 8'h08);
        chk("single_valid_e0", 8'(irq_valid), 8'd0);
        step();
        chk("single_valid_e1", 8'(irq_valid), 8'd1);
        chk("single_idx_e1", 8'(irq_idx), 8'd3);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        chk("single_pend_ack", pending, 8'h00);
        chk("single_valid_ack", 8'(irq_valid), 8'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("single_no_regrant", 8'(irq_valid), 8'd0);
        end
        req_in = 8'h00;
        step();

        // Priority and hold
        req_in = 8'h22;
        step();
        req_in = 8'h00;
        step();
        chk("prio_idx5", 8'(irq_idx), 8'd5);
        req_in = 8'h80;
        step();
        req_in = 8'h00;
        step();
        chk("hold_valid", 8'(irq_valid), 8'd1);
        chk("hold_idx5", 8'(irq_idx), 8'd5);
        irq_ack = 1'b1;
        step();
        irq_ack = 1'b0;
        step();
        chk("gap_no_valid", 8'(irq_valid), 8'd0);
        step();
        chk("next_at_ea2", 8'(irq_valid), 8'd1);
        wait_grant(3'd7, 4);
        wait_grant(3'd1, 4);

        // Masking
        mask   = 8'h7F;
        req_in = 8'h84;
        step();
        req_in = 8'h00;
        wait_grant(3'd2, 4);
        repeat (3) step();
        chk("mask_pend80", pending, 8'h80);
        chk("mask_no_valid", 8'(irq_valid), 8'd0);
        mask = 8'hFF;
        wait_grant(3'd7, 3);

        // Set-wins race on bit 4
        repeat (2) step();
        req_in = 8'h10;
        step();
        req_in = 8'h00;
        while (!irq_valid) step();
        chk("race_idx4", 8'(irq_idx), 8'd4);
        irq_ack = 1'b1;
        req_in  = 8'h10;
        step();
        irq_ack = 1'b0;
        req_in  = 8'h00;
        chk("race_pend4", pending, 8'h10);
        wait_grant(3'd4, 4);

        // Held ack with bits 6,3,0 pending
        repeat (2) step();
        req_in = 8'h49;
        step();
        req_in  = 8'h00;
        irq_ack = 1'b1;
        gi = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            held_v[i] = irq_valid;
            if (irq_valid && gi < 3) begin
                held_i[gi] = irq_idx;
                gi++;
            end
        end
        irq_ack = 1'b0;
        chk("held_pattern", held_v[7:0], 8'b0100_1001);
        chk("held_g0", 8'(held_i[0]), 8'd6);
        chk("held_g1", 8'(held_i[1]), 8'd3);
        chk("held_g2", 8'(held_i[2]), 8'd0);

        // Async reset while presenting
        step();
        req_in = 8'h03;
        step();
        req_in = 8'h00;
        step();
        chk("pre_rst_valid", 8'(irq_valid), 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_valid_drop", 8'(irq_valid), 8'd0);
        chk("rst_pend_clear", pending, 8'h00);
        chk("rst_idx_clear", 8'(irq_idx), 8'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // Randomized traffic against the model
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) == 0) req_in = req_in ^ 8'($urandom);
            if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
            if ($urandom_range(0, 7) == 0) mask = 8'hFF;
            irq_ack = 1'($urandom_range(0, 1));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
